// File: rtl/fa_pkg.sv
// Shared definitions for the bit-serial full-adder controller.
//   state_e    : controller state encoding (IDLE, ISSUE, DONE)
//   W_DEF      : default operand width
//   FA_LAT_DEF : default FA cell latency in edges
package fa_pkg;

  localparam int unsigned W_DEF      = 4;
  localparam int unsigned FA_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fa_serial_sequencer.sv
// Bit-serial controller that drives one external registered 1-bit full-adder
// cell LSB-first to perform a W-bit add, then holds the result for the consumer.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   in_valid/in_ready            : request handshake (op_a, op_b, op_cin)
//   out_valid/out_ready          : result handshake (out_sum, out_cout)
//   busy                         : operation in flight
//   fa_a/fa_b/fa_cin             : to the FA cell
//   fa_sum/fa_cout               : from the FA cell
module fa_serial_sequencer
  import fa_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned FA_LAT = FA_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         busy,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_cin,
  input  logic         fa_sum,
  input  logic         fa_cout
);

  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned PW = $clog2(FA_LAT + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
  localparam logic [PW-1:0] LAST_PH  = PW'(FA_LAT);

  state_e          r_state;
  logic [BW-1:0]   r_bit;
  logic [PW-1:0]   r_ph;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_fa_cin;

  // Handshake/status flags are direct decodes of the state register.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == ISSUE);

  // Operand shadows shift right each bit, so their LSB is the bit on the FA cell.
  assign fa_a     = r_a[0];
  assign fa_b     = r_b[0];
  assign fa_cin   = r_fa_cin;
  assign out_sum  = r_sum;
  assign out_cout = r_cout;

  // Controller FSM: accept, step one bit every FA_LAT+1 cycles, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_bit    <= '0;
      r_ph     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_fa_cin <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= op_a;
            r_b      <= op_b;
            r_fa_cin <= op_cin;
            r_bit    <= '0;
            r_ph     <= '0;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_ph != LAST_PH) begin
            r_ph <= r_ph + PW'(1);
          end else begin
            // FA output now reflects the inputs held since this bit started.
            for (int unsigned i = 0; i < W; i++) begin
              if (r_bit == BW'(i)) r_sum[i] <= fa_sum;
            end
            if (r_bit != LAST_BIT) begin
              r_bit    <= r_bit + BW'(1);
              r_ph     <= '0;
              r_a      <= r_a >> 1;
              r_b      <= r_b >> 1;
              r_fa_cin <= fa_cout;
            end else begin
              r_cout  <= fa_cout;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
